// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared definitions for the serial packed-BCD subtractor.
package bcd_serial_subtractor_pkg;

  localparam int unsigned BCD_W     = 4;
  localparam int unsigned BCD_MAX   = 9;
  localparam int unsigned BCD_RADIX = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when a nibble holds a legal decimal digit.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
    return (digit <= BCD_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract cell: d = x - y - bi with decimal borrow.
module bcd_digit_sub
  import bcd_serial_subtractor_pkg::*;
(
  input  logic [BCD_W-1:0] i_x,
  input  logic [BCD_W-1:0] i_y,
  input  logic             i_bi,
  output logic [BCD_W-1:0] o_d,
  output logic             o_bo
);

  logic signed [BCD_W:0] w_t;
  logic signed [BCD_W:0] w_adj;

  // Signed difference; a negative result is folded back into 0..9 by adding the radix.
  always_comb begin
    w_t   = $signed({1'b0, i_x}) - $signed({1'b0, i_y}) - $signed({{BCD_W{1'b0}}, i_bi});
    w_adj = w_t + $signed((BCD_W + 1)'(BCD_RADIX));
    o_bo  = w_t[BCD_W];
    o_d   = w_t[BCD_W] ? w_adj[BCD_W-1:0] : w_t[BCD_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Multi-digit packed-BCD subtractor, one digit per clock, LSD first, start/busy/done handshake.
module bcd_serial_subtractor
  import bcd_serial_subtractor_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [BCD_W*DIGITS-1:0]   i_a,
  input  logic [BCD_W*DIGITS-1:0]   i_b,
  input  logic                      i_bin,
  output logic [BCD_W*DIGITS-1:0]   o_diff,
  output logic                      o_bout,
  output logic                      o_err,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t                    r_state;
  logic [BCD_W*DIGITS-1:0]   r_a;
  logic [BCD_W*DIGITS-1:0]   r_b;
  logic [BCD_W*DIGITS-1:0]   r_diff;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_borrow;
  logic                      r_bout;
  logic                      r_err;
  logic                      r_busy;
  logic                      r_done;

  logic                      w_ops_ok;
  logic [BCD_W-1:0]          w_x;
  logic [BCD_W-1:0]          w_y;
  logic [BCD_W-1:0]          w_d;
  logic                      w_bo;

  // Validate every digit of the live operands; only consulted when a start is accepted.
  always_comb begin
    w_ops_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!bcd_valid(i_a[i*BCD_W +: BCD_W]) || !bcd_valid(i_b[i*BCD_W +: BCD_W])) begin
        w_ops_ok = 1'b0;
      end
    end
  end

  // Select the current digit pair from the latched operands.
  always_comb begin
    w_x = r_a[r_idx*BCD_W +: BCD_W];
    w_y = r_b[r_idx*BCD_W +: BCD_W];
  end

  bcd_digit_sub u_digit (
    .i_x  (w_x),
    .i_y  (w_y),
    .i_bi (r_borrow),
    .o_d  (w_d),
    .o_bo (w_bo)
  );

  // Control FSM with registered outputs; busy mirrors the CALC state, done is a one-cycle pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_idx  <= '0;
            if (!w_ops_ok) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= DONE;
            end else begin
              r_err    <= 1'b0;
              r_borrow <= i_bin;
              r_busy   <= 1'b1;
              r_state  <= CALC;
            end
          end
        end
        CALC: begin
          r_diff[r_idx*BCD_W +: BCD_W] <= w_d;
          r_borrow                     <= w_bo;
          if (r_idx == LAST_IDX) begin
            r_bout  <= w_bo;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_diff = r_diff;
  assign o_bout = r_bout;
  assign o_err  = r_err;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (DIGITS=4) against an integer reference model.
module tb_bcd_serial_subtractor;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        i_bin;
  logic [15:0] o_diff;
  logic        o_bout;
  logic        o_err;
  logic        o_busy;
  logic        o_done;

  int n_checks = 0;
  int n_errors = 0;

  bcd_serial_subtractor #(
    .DIGITS (4)
  ) u_dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_bin   (i_bin),
    .o_diff  (o_diff),
    .o_bout  (o_bout),
    .o_err   (o_err),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the digit values.
  function automatic bit has_bad_digit(input logic [15:0] v);
    logic [3:0] nib;
    for (int i = 0; i < 4; i++) begin
      nib = v[i*4 +: 4];
      if (nib > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int bcd_to_int(input logic [15:0] v);
    int r = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      r += int'(v[i*4 +: 4]) * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int n);
    logic [15:0] v = '0;
    for (int i = 0; i < 4; i++) begin
      v[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Runs one operation starting at a falling edge; returns at the falling edge where done is seen.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input bit scramble, input bit restart);
    logic [15:0] exp_diff;
    logic        exp_bout;
    logic        exp_err;
    int          r;
    int          cyc;
    int          busy_cnt;

    exp_err = has_bad_digit(a) || has_bad_digit(b);
    if (exp_err) begin
      exp_diff = '0;
      exp_bout = 1'b0;
    end else begin
      r        = bcd_to_int(a) - bcd_to_int(b) - int'(bin);
      exp_bout = (r < 0);
      if (r < 0) r += 10000;
      exp_diff = int_to_bcd(r);
    end

    i_a     = a;
    i_b     = b;
    i_bin   = bin;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start  = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    check({tag, "_diff_clear"}, 32'(o_diff), 32'd0);
    if (scramble) begin
      i_a   = 16'($urandom);
      i_b   = 16'($urandom);
      i_bin = 1'($urandom);
    end
    while (!o_done && cyc < 40) begin
      if (o_busy) busy_cnt++;
      if (restart) begin
        i_start = (cyc == 2);
        i_a     = 16'h9999;
        i_b     = 16'h0000;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_start = 1'b0;
    check({tag, "_done_seen"}, 32'(o_done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), exp_err ? 32'd2 : 32'd6);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), exp_err ? 32'd0 : 32'd4);
    check({tag, "_diff"}, 32'(o_diff), 32'(exp_diff));
    check({tag, "_bout"}, 32'(o_bout), 32'(exp_bout));
    check({tag, "_err"}, 32'(o_err), 32'(exp_err));
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;

    i_rst   = 1'b1;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_bin   = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_diff", 32'(o_diff), 32'd0);
    check("rst_flags", {28'd0, o_bout, o_err, o_busy, o_done}, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    run_op("basic", 16'h5432, 16'h1234, 1'b0, 1'b0, 1'b0);
    run_op("ripple", 16'h1000, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("neg", 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("zero_bin", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("equal", 16'h8765, 16'h8765, 1'b0, 1'b0, 1'b0);
    run_op("bad_a", 16'h12A4, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op("ignored_start", 16'h5432, 16'h1234, 1'b0, 1'b0, 1'b1);
    run_op("latched", 16'h7301, 16'h2958, 1'b1, 1'b1, 1'b0);

    // Results must hold while idle.
    repeat (3) @(negedge i_clk);
    check("hold_diff", 32'(o_diff), 32'h4342);
    check("hold_done", 32'(o_done), 32'd0);

    // Asynchronous reset in the middle of CALC.
    i_a     = 16'h5432;
    i_b     = 16'h1234;
    i_bin   = 1'b0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    check("pre_rst_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    #1;
    check("mid_rst_diff", 32'(o_diff), 32'd0);
    check("mid_rst_flags", {28'd0, o_bout, o_err, o_busy, o_done}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    run_op("after_rst", 16'h0050, 16'h0049, 1'b0, 1'b0, 1'b0);

    // Randomized back-to-back operations, occasionally with an illegal digit.
    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 7) == 0) ra[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) rb[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
      run_op("rand", ra, rb, 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
